// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the fpdiv front end: FSM states,
// IEEE single operand width, the operand bundle and round-mode codes.
package fpdiv_pkg;

  localparam int FP_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic RM_RNE = 1'b0;
  localparam logic RM_RTZ = 1'b1;

  typedef struct packed {
    logic [FP_WIDTH-1:0] n;
    logic [FP_WIDTH-1:0] d;
    logic                rm;
  } fpdiv_req_t;

endpackage

// File: rtl/fpdiv_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first set request found
// when searching upward from ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             grant_valid
);

  int               idx;
  logic [PTR_W-1:0] sel;

  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = PTR_W'(idx);
      if (!grant_valid && req[sel]) begin
        grant[sel]  = 1'b1;
        grant_idx   = sel;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpdiv_arbiter.sv
// Shares one iterative fpdiv core between NREQ requesters. One operation
// is in flight at a time: accept, hold operands for LAT_CYCLES, capture
// the quotient, then return it to the owning requester.
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high. req_ready is combinational from req_valid (only in
// IDLE), so requesters must not make req_valid depend on req_ready.
// rsp_valid stays high with rsp_q stable until the owner's rsp_ready.
module fpdiv_arbiter
  import fpdiv_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int WIDTH      = FP_WIDTH,
  parameter int LAT_CYCLES = 16,
  localparam int PTR_W     = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0] req_n,
  input  logic [NREQ-1:0][WIDTH-1:0] req_d,
  input  logic [NREQ-1:0]            req_rm,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [WIDTH-1:0]           rsp_q,
  output logic                       core_start,
  output logic [WIDTH-1:0]           core_n,
  output logic [WIDTH-1:0]           core_d,
  output logic                       core_rm,
  input  logic [WIDTH-1:0]           core_q,
  output logic                       busy,
  output state_t                     dbg_state,
  output logic [PTR_W-1:0]           dbg_ptr
);

  localparam int               CNT_W    = $clog2(LAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

  state_t           state, state_nx;
  logic [PTR_W-1:0] ptr, owner, grant_idx;
  logic [NREQ-1:0]  grant;
  logic             grant_valid;
  logic [CNT_W-1:0] cnt;
  logic             accept, finish, release_op;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req         (req_valid),
    .ptr         (ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // State register; reset also aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state plus the handshake/launch strobes for the current state.
  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    rsp_valid  = '0;
    core_start = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;
    release_op = 1'b0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (grant_valid) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        // cnt is still at its load value only in the first BUSY cycle.
        core_start = (cnt == CNT_INIT);
        if (cnt == '0) begin
          finish   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) begin
          release_op = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, iteration counter, result capture and pointer rotation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      core_n  <= '0;
      core_d  <= '0;
      core_rm <= 1'b0;
      rsp_q   <= '0;
    end else begin
      if (accept) begin
        core_n  <= req_n[grant_idx];
        core_d  <= req_d[grant_idx];
        core_rm <= req_rm[grant_idx];
        owner   <= grant_idx;
        cnt     <= CNT_INIT;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (finish) rsp_q <= core_q;
      if (release_op) ptr <= (owner == PTR_LAST) ? '0 : owner + 1'b1;
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Bench for fpdiv_arbiter: a stand-in fpdiv core, a cycle-level reference
// model of the sharing protocol, a quotient scoreboard and directed plus
// randomized scenarios.
module tb_fpdiv_arbiter;
  import fpdiv_pkg::*;

  localparam int NREQ  = 2;
  localparam int WIDTH = 32;
  localparam int LAT   = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic [NREQ-1:0]            req_valid, req_ready, req_rm;
  logic [NREQ-1:0][WIDTH-1:0] req_n, req_d;
  logic [NREQ-1:0]            rsp_valid, rsp_ready;
  logic [WIDTH-1:0]           rsp_q, core_n, core_d, core_q;
  logic                       core_start, core_rm, busy;
  state_t                     dbg_state;
  logic [0:0]                 dbg_ptr;

  fpdiv_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT_CYCLES(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_n      (req_n),
    .req_d      (req_d),
    .req_rm     (req_rm),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_q      (rsp_q),
    .core_start (core_start),
    .core_n     (core_n),
    .core_d     (core_d),
    .core_rm    (core_rm),
    .core_q     (core_q),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .dbg_ptr    (dbg_ptr)
  );

  // ---------------- core stand-in ----------------
  function automatic logic [31:0] core_fn(input logic [31:0] n, input logic [31:0] d,
                                          input logic rm);
    if (n == 32'h3f80_0000 && d == 32'h4000_0000 && rm == RM_RNE) return 32'h3f00_0000;
    if (n == 32'h4040_0000 && d == 32'h3f80_0000 && rm == RM_RNE) return 32'h4040_0000;
    return {n[15:0] ^ d[31:16], n[31:16] + d[15:0]} ^ {31'd0, rm};
  endfunction

  int          core_cc = 1000;
  logic [31:0] core_res = '0;

  // Quotient becomes valid LAT cycles after the launch pulse; garbage before.
  always @(negedge clk) begin
    if (core_start) begin
      core_cc  = 0;
      core_res = core_fn(core_n, core_d, core_rm);
    end else if (core_cc < 1000) begin
      core_cc++;
    end
    core_q = (core_cc >= LAT - 1) ? core_res : 32'hdead_beef;
  end

  // ---------------- reference model / scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  bit          m_busy = 0;
  int          m_since = 0;
  int          m_owner = 0;
  int          m_ptr = 0;
  fpdiv_req_t  m_op = '0;
  logic [31:0] m_rsp_q = '0;
  logic [WIDTH-1:0] exp_q[$];
  int          grant_log[$];
  int          ops_left[NREQ];
  int          rsp_cnt[NREQ];
  int          cyc = 0, acc_cyc = 0, last_rsp_cyc = 0, last_gap = 0, lat_meas = 0;
  int          n_starts = 0, n_accepts = 0, n_rsps = 0;
  logic [31:0] last_rsp_q = '0;
  logic [NREQ-1:0] prev_rv = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // First valid requester searching upward from ptr with wrap; -1 if none.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic load_op(input int r);
    req_n[r]  = $urandom;
    req_d[r]  = $urandom;
    req_rm[r] = 1'($urandom_range(0, 1));
  endtask

  task automatic start_op(input int r, input logic [31:0] n, input logic [31:0] d,
                          input logic rm, input int count);
    req_n[r]     = n;
    req_d[r]     = d;
    req_rm[r]    = rm;
    req_valid[r] = 1'b1;
    ops_left[r]  = count;
  endtask

  // One clock: check outputs at negedge, advance model across posedge,
  // then let the requester drivers react to any accept.
  task automatic tick();
    int g, acc;
    logic [NREQ-1:0] exp_rdy, exp_rv;
    @(negedge clk);
    g       = rr_pick(req_valid, m_ptr);
    exp_rdy = '0;
    if (!m_busy && g >= 0) exp_rdy[g] = 1'b1;
    exp_rv = '0;
    if (m_busy && m_since > LAT) exp_rv[m_owner] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("busy", busy, m_busy);
    chk("core_start", core_start, m_busy && m_since == 1);
    chk("core_n", core_n, m_op.n);
    chk("core_d", core_d, m_op.d);
    chk("core_rm", core_rm, m_op.rm);
    chk("rsp_q", rsp_q, m_rsp_q);
    chk("ptr", dbg_ptr, m_ptr);
    if (core_start) n_starts++;
    if (rsp_valid != '0 && prev_rv == '0) lat_meas = cyc - acc_cyc - 1;
    prev_rv = rsp_valid;
    acc = -1;
    if (!reset) begin
      m_busy  = 0;
      m_since = 0;
      m_ptr   = 0;
      m_op    = '0;
      m_rsp_q = '0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (g >= 0) begin
        m_busy  = 1;
        m_since = 1;
        m_owner = g;
        m_op.n  = req_n[g];
        m_op.d  = req_d[g];
        m_op.rm = req_rm[g];
        exp_q.push_back(core_fn(req_n[g], req_d[g], req_rm[g]));
        grant_log.push_back(g);
        n_accepts++;
        acc      = g;
        acc_cyc  = cyc;
        last_gap = cyc - last_rsp_cyc;
      end
    end else begin
      if (m_since == LAT) m_rsp_q = core_fn(m_op.n, m_op.d, m_op.rm);
      if (m_since > LAT && rsp_ready[m_owner]) begin
        if (exp_q.size() > 0) chk("rsp_q_scoreboard", rsp_q, exp_q.pop_front());
        rsp_cnt[m_owner]++;
        n_rsps++;
        last_rsp_q   = rsp_q;
        last_rsp_cyc = cyc;
        m_busy       = 0;
        m_ptr        = (m_owner + 1) % NREQ;
      end else begin
        m_since++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc >= 0) begin
      ops_left[acc]--;
      if (ops_left[acc] > 0) load_op(acc);
      else req_valid[acc] = 1'b0;
    end
  endtask

  function automatic bit all_done();
    for (int r = 0; r < NREQ; r++) if (ops_left[r] != 0) return 0;
    return !m_busy;
  endfunction

  task automatic run_ops(input int max_cyc, input bit rnd_rdy);
    for (int i = 0; i < max_cyc; i++) begin
      if (all_done()) break;
      if (rnd_rdy) rsp_ready = 2'($urandom_range(0, 3));
      tick();
    end
    rsp_ready = '1;
    chk("run_timeout", all_done(), 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // ---------------- directed scenario sequence ----------------
  initial begin
    int s, r0, r1, n0;
    reset     = 1'b0;
    req_valid = '0;
    req_n     = '0;
    req_d     = '0;
    req_rm    = '0;
    rsp_ready = '1;
    for (int r = 0; r < NREQ; r++) begin ops_left[r] = 0; rsp_cnt[r] = 0; end
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset state.
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_n", core_n, 0);
    chk("rst_rsp_q", rsp_q, 0);
    chk("rst_state", dbg_state, IDLE);
    repeat (3) tick();

    // Single op from requester 0.
    start_op(0, 32'h3f80_0000, 32'h4000_0000, RM_RNE, 1);
    run_ops(200, 0);
    chk("single_q", last_rsp_q, 32'h3f00_0000);
    chk("single_latency", lat_meas, LAT);
    chk("single_cnt0", rsp_cnt[0], 1);
    chk("single_cnt1", rsp_cnt[1], 0);

    // Contention from pointer 0: req0 first, req1 right after.
    do_reset();
    s = grant_log.size();
    start_op(0, 32'h3f80_0000, 32'h4000_0000, RM_RNE, 1);
    start_op(1, 32'h4040_0000, 32'h3f80_0000, RM_RNE, 1);
    run_ops(200, 0);
    chk("contend_first", grant_log[s], 0);
    chk("contend_second", grant_log[s+1], 1);
    chk("contend_gap", last_gap, 1);
    chk("contend_q1", last_rsp_q, 32'h4040_0000);

    // Fairness: both hold valid for six operations.
    s  = grant_log.size();
    r0 = rsp_cnt[0];
    r1 = rsp_cnt[1];
    load_op(0);
    load_op(1);
    req_valid   = '1;
    ops_left[0] = 3;
    ops_left[1] = 3;
    run_ops(400, 0);
    for (int i = 0; i < 6; i++) chk("fair_order", grant_log[s+i], i % 2);
    chk("fair_cnt0", rsp_cnt[0] - r0, 3);
    chk("fair_cnt1", rsp_cnt[1] - r1, 3);

    // Backpressure: owner 0 stalls in DONE while req1 waits; non-owner ready ignored.
    rsp_ready = 2'b10;
    load_op(0);
    req_valid[0] = 1'b1;
    ops_left[0]  = 1;
    tick();
    load_op(1);
    req_valid[1] = 1'b1;
    ops_left[1]  = 1;
    for (int i = 0; i < 100; i++) begin
      if (m_busy && m_since > LAT) break;
      tick();
    end
    chk("bp_reached_done", m_busy && m_since > LAT, 1);
    n0 = n_accepts;
    repeat (10) tick();
    chk("bp_no_accept", n_accepts, n0);
    chk("bp_state", dbg_state, DONE);
    rsp_ready = 2'b11;
    run_ops(200, 0);

    // Reset mid-BUSY after moving the pointer to 1.
    start_op(0, $urandom, $urandom, RM_RTZ, 1);
    run_ops(200, 0);
    chk("pre_rst_ptr", dbg_ptr, 1);
    start_op(0, $urandom, $urandom, RM_RNE, 1);
    for (int i = 0; i < 100; i++) begin
      if (m_busy && m_since == LAT - 5) break;
      tick();
    end
    chk("mid_busy_reached", m_busy && m_since == LAT - 5, 1);
    n0 = n_rsps;
    do_reset();
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_ptr", dbg_ptr, 0);
    chk("abort_state", dbg_state, IDLE);
    repeat (LAT + 6) tick();
    chk("abort_no_rsp", n_rsps, n0);

    // Operand stability while the requester keeps changing its inputs.
    start_op(0, $urandom, $urandom, RM_RTZ, 1);
    tick();
    for (int i = 0; i < LAT + 4 && m_busy; i++) begin
      req_n[0]  = $urandom;
      req_d[0]  = $urandom;
      req_rm[0] = ~req_rm[0];
      tick();
    end
    run_ops(100, 0);

    // Randomized traffic with random response backpressure.
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        load_op(r);
        req_valid[r] = 1'($urandom_range(0, 1));
        ops_left[r]  = req_valid[r] ? $urandom_range(2, 5) : 0;
      end
      run_ops(3000, 1);
      repeat ($urandom_range(0, 3)) tick();
    end

    chk("start_per_op", n_starts, n_accepts);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
